// File: rtl/cbi980_stream_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cbi980_stream_ctl                                               |
// | Purpose  : Per-channel RX/TX sample FIFOs between the CPU and codec_if,    |
// |            with sample-format conversion and level/sticky-error flags.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cbi980_stream_ctl #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxen,
  input  logic        txen,
  input  logic        irq_rst,
  input  logic [2:0]  octet_cnt,
  input  logic        dout_wr_en,
  input  logic        dout_ch,
  input  logic [31:0] dout_data,
  output logic        wr_drop,
  input  logic        din_rd_en,
  input  logic        din_ch,
  output logic [31:0] din_data,
  input  logic [1:0]  aud_dout_vld,
  input  logic [23:0] aud_dout,
  input  logic [1:0]  aud_din_ack,
  output logic [23:0] aud_din0,
  output logic [23:0] aud_din1,
  output logic [1:0]  rxne,
  output logic [1:0]  rxf,
  output logic [1:0]  txnf,
  output logic [1:0]  txe,
  output logic [1:0]  rx_ovf,
  output logic [1:0]  tx_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

  // Codec capture: keep the top n octets, sign-extended to a CPU word.
  function automatic logic [31:0] rx_fmt(input logic [23:0] s, input logic [1:0] n);
    case (n)
      2'd1:    return {{24{s[23]}}, s[23:16]};
      2'd2:    return {{16{s[23]}}, s[23:8]};
      default: return {{8{s[23]}}, s};
    endcase
  endfunction

  // CPU word to codec: low n octets left-justified in the 24-bit sample.
  function automatic logic [23:0] tx_fmt(input logic [23:0] w, input logic [1:0] n);
    case (n)
      2'd1:    return {w[7:0], 16'h0};
      2'd2:    return {w[15:0], 8'h0};
      default: return w;
    endcase
  endfunction

  logic [1:0]        w_n;
  logic [1:0][31:0]  w_rx_head;
  logic [1:0]        w_rx_empty;
  logic [1:0][23:0]  w_aud_din;
  logic [1:0]        w_wr_drop;
  logic [1:0]        w_ovf_set;
  logic [1:0]        w_unf_set;

  always_comb begin
    w_n = 2'd3;
    if (octet_cnt == 3'd1)      w_n = 2'd1;
    else if (octet_cnt == 3'd2) w_n = 2'd2;
  end

  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      logic [31:0]   r_rx_mem [DEPTH];
      logic [31:0]   r_tx_mem [DEPTH];
      logic [AW-1:0] r_rx_wr, r_rx_rd, r_tx_wr, r_tx_rd;
      logic [AW:0]   r_rx_cnt, r_tx_cnt;
      logic          w_rx_full, w_rx_push, w_rx_pop, w_rx_vld;
      logic          w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_sel;

      assign w_rx_full     = (r_rx_cnt == c_full);
      assign w_rx_empty[g] = (r_rx_cnt == '0);
      assign w_rx_head[g]  = r_rx_mem[r_rx_rd];
      assign w_rx_pop      = din_rd_en && (din_ch == 1'(g)) && !w_rx_empty[g];
      assign w_rx_vld      = aud_dout_vld[g] && rxen;
      // A same-cycle host read frees the slot, so a full FIFO can still accept.
      assign w_rx_push     = w_rx_vld && (!w_rx_full || w_rx_pop);
      assign w_ovf_set[g]  = w_rx_vld && !w_rx_push;

      assign w_tx_empty    = (r_tx_cnt == '0);
      assign w_tx_full     = (r_tx_cnt == c_full);
      assign w_tx_pop      = aud_din_ack[g] && txen && !w_tx_empty;
      assign w_unf_set[g]  = aud_din_ack[g] && txen && w_tx_empty;
      assign w_tx_sel      = dout_wr_en && (dout_ch == 1'(g));
      assign w_tx_push     = w_tx_sel && (!w_tx_full || w_tx_pop);
      assign w_wr_drop[g]  = w_tx_sel && !w_tx_push;

      assign w_aud_din[g]  = (txen && !w_tx_empty) ? tx_fmt(r_tx_mem[r_tx_rd][23:0], w_n) : 24'h0;

      assign rxne[g] = !w_rx_empty[g];
      assign rxf[g]  = w_rx_full;
      assign txnf[g] = (r_tx_cnt < c_full);
      assign txe[g]  = w_tx_empty;

      always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_fmt(aud_dout, w_n);
        if (w_tx_push) r_tx_mem[r_tx_wr] <= dout_data;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rx_wr  <= '0;
          r_rx_rd  <= '0;
          r_rx_cnt <= '0;
          r_tx_wr  <= '0;
          r_tx_rd  <= '0;
          r_tx_cnt <= '0;
        end else begin
          if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
          if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
          if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
          if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
          r_rx_cnt <= r_rx_cnt + (AW+1)'(w_rx_push) - (AW+1)'(w_rx_pop);
          r_tx_cnt <= r_tx_cnt + (AW+1)'(w_tx_push) - (AW+1)'(w_tx_pop);
        end
      end
    end
  endgenerate

  assign aud_din0 = w_aud_din[0];
  assign aud_din1 = w_aud_din[1];
  assign wr_drop  = |w_wr_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_data <= 32'h0;
      rx_ovf   <= 2'b00;
      tx_unf   <= 2'b00;
    end else begin
      if (din_rd_en) din_data <= w_rx_empty[din_ch] ? 32'h0 : w_rx_head[din_ch];
      // Set events take priority over a coincident clear.
      rx_ovf <= (irq_rst ? 2'b00 : rx_ovf) | w_ovf_set;
      tx_unf <= (irq_rst ? 2'b00 : tx_unf) | w_unf_set;
    end
  end

endmodule
`default_nettype wire

// File: doc/cbi980_stream_ctl.md
# cbi980_stream_ctl

Sample-stream controller between the CPU register file and `codec_if`. Owns the per-channel (0 = left, 1 = right) RX and TX sample FIFOs and schedules codec-side transfers off the `aud_dout_vld` / `aud_din_ack` strobes. Converts between the 24-bit codec sample format and the CPU word format selected by `octet_cnt`. Maintains the FIFO level flags and the sticky overflow/underflow flags that `cbi980_core` exposes in SR and uses for interrupts.

## Interface
- `DEPTH`, 16: entries per FIFO; power of two, ≥2; `AW = log2(DEPTH)`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rxen`, `txen`  in  1 each  capture / playback enables (CR).
- `irq_rst`  in  1  one-cycle pulse; clears sticky flags.
- `octet_cnt`  in  3  octets per CPU sample word; 1..3 valid; 0 or >3 treated as 3.
- `dout_wr_en`  in  1  host TX write strobe.
- `dout_ch`  in  1  host TX channel.
- `dout_data`  in  32  host TX word.
- `wr_drop`  out  1  pulse: host TX write rejected (FIFO full).
- `din_rd_en`  in  1  host RX read strobe.
- `din_ch`  in  1  host RX channel.
- `din_data`  out  32  RX word, registered.
- `aud_dout_vld`  in  2  per-channel capture strobe from `codec_if`.
- `aud_dout`  in  24  captured sample.
- `aud_din_ack`  in  2  per-channel playback consume strobe.
- `aud_din0`, `aud_din1`  out  24 each  playback samples.
- `rxne`, `rxf`, `txnf`, `txe`  out  2 each  level flags, bit = channel.
- `rx_ovf`, `tx_unf`  out  2 each  sticky error flags.

## Operation
- Four FIFOs (RX0, RX1, TX0, TX1), each 32-bit × DEPTH with AW-bit head/tail pointers and an (AW+1)-bit count. Pointers wrap modulo DEPTH.
- Level flags:
  - `rxne = count != 0`; `rxf = count == DEPTH`.
  - `txnf = count < DEPTH`; `txe = count == 0`.
- RX format: n = octet count; word = sign-extension to 32 bits of `aud_dout[23 -: 8n]`.
- TX format: sample = `{dout_data[8n-1:0], (24-8n) zero bits}`; the conversion is applied at pop time using the current `octet_cnt`.
- Capture: `aud_dout_vld[c]` with `rxen=1`:
  - RXc not full: push.
  - RXc full: drop the sample and set `rx_ovf[c]`.
  - With `rxen=0`, strobes are ignored and no flag is set.
- Playback:
  - `aud_dinc` shows the formatted TXc head when `txen=1` and TXc is non-empty; otherwise it is 0.
  - `aud_din_ack[c]` with `txen=1`:
    - TXc non-empty: pop.
    - TXc empty: set `tx_unf[c]`; no pointer change.
- Host write: `dout_wr_en` pushes to TX`dout_ch` when not full or when the same FIFO pops in the same cycle. Otherwise the word is discarded and `wr_drop=1` for that cycle.
- Host read:
  - `din_rd_en` on a non-empty RX`din_ch`: `din_data` ← head word and pop.
  - On empty: `din_data` ← 0 and no pointer change.
- Capture push and host read on the same RX FIFO in one cycle: both take effect, count unchanged.
  - Full + push + pop: push accepted, no overflow.
  - Empty + push + read: read returns 0, push lands.
- Sticky flags: an `irq_rst` pulse clears all four bits. A set event in the same cycle wins.
- Both channels are processed independently in the same cycle; there is no arbitration between channels.

## Timing
- Reset values (next edge after `rst` high):
  - All pointers and counts 0 → `rxne=0`, `rxf=0`, `txnf=2'b11`, `txe=2'b11`.
  - `rx_ovf = tx_unf = 0`; `din_data = 0`; `wr_drop = 0`; `aud_din0 = aud_din1 = 0`.
- `rst` mid-stream flushes all FIFOs; the RAM contents are don't-care.
- Push at edge k:
  - Flags reflect the new count after edge k.
  - `aud_dinc` reflects a new head combinationally from the pointers and RAM, with no extra latency.
- `din_data` is valid the cycle after `din_rd_en`. Back-to-back reads return consecutive entries.
- `wr_drop` is combinational from `dout_wr_en` and FIFO state.
- `rx_ovf` / `tx_unf` assert the cycle after the offending strobe.

## Test plan
- After reset:
  - Write 0x00ABCDEF to ch0 with `octet_cnt=3`, `txen=1`.
  - Expect `aud_din0=0xABCDEF`, then `txe[0]=0`.
  - Ack → `txe[0]=1`, `aud_din0=0`.
- Fill TX1 with 16 words:
  - After 16 writes, `txnf[1]=0`.
  - 17th write → `wr_drop=1`, count stays 16.
  - 17th write plus `aud_din_ack[1]` in the same cycle → accepted.
- `rxen=1`, `octet_cnt=2`, capture 0x80_1234 on ch1 → read returns 0xFFFF8012. With `octet_cnt=1`, capture 0x7F0000 → 0x0000007F.
- Overflow and underflow:
  - 17 captures on ch0 → `rx_ovf[0]=1`, the 17th sample is lost, and the first 16 read back in order (including across pointer wrap).
  - Ack on empty TX0 → `tx_unf[0]=1`.
  - `irq_rst` → both clear.
  - `irq_rst` coincident with a new overflow → flag stays 1.
- Read from empty RX0 → `din_data=0`, `rxne[0]=0`, and pointers are unchanged (next capture reads correctly).
- Assert `rst` with 5 entries in every FIFO → all flags return to reset values and `aud_din0 = aud_din1 = 0` the next cycle.
